// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control front end:
// FSM state encodings and the board button index map.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    localparam int BTN_CLR   = 0;
    localparam int BTN_START = 2;
    localparam int BTN_STOP  = 4;

endpackage

// File: rtl/stopwatch_ctrl_debounce.sv
// One button channel: 2-flop synchroniser, stable-count debouncer and
// rising-edge detector producing a single-cycle press event.
module btn_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_deb;
    logic          r_deb_q;
    logic [CW-1:0] r_cnt;

    // The level only flips after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_deb   <= 1'b0;
            r_deb_q <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1    <= raw;
            r_s2    <= r_s1;
            r_deb_q <= r_deb;
            if (r_s2 != r_deb) begin
                if (r_cnt == CW'(DEB_CYCLES - 1)) begin
                    r_deb <= r_s2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign level = r_deb;
    assign press = r_deb & ~r_deb_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced buttons drive the IDLE/RUN/PAUSE FSM, which
// gates the ms/second prescaler and issues clear commands to the datapath.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int MS_LIMIT   = 100000,
    parameter int SEC_LIMIT  = 1000,
    parameter int DEB_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] btn,
    output logic       run,
    output logic       sec_tick,
    output logic       ms_tick,
    output logic       cnt_clr,
    output logic [1:0] state
);

    localparam int MS_W  = $clog2(MS_LIMIT);
    localparam int SEC_W = (SEC_LIMIT > 1) ? $clog2(SEC_LIMIT) : 1;

    logic w_start;
    logic w_stop;
    logic w_clr;
    logic w_lvl_start;
    logic w_lvl_stop;
    logic w_lvl_clr;
    logic w_unused;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
        .clk(clk), .rst_n(rst_n), .raw(btn[BTN_START]), .level(w_lvl_start), .press(w_start)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_stop (
        .clk(clk), .rst_n(rst_n), .raw(btn[BTN_STOP]), .level(w_lvl_stop), .press(w_stop)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
        .clk(clk), .rst_n(rst_n), .raw(btn[BTN_CLR]), .level(w_lvl_clr), .press(w_clr)
    );

    assign w_unused = ^{btn[1], btn[3], w_lvl_start, w_lvl_stop, w_lvl_clr};

    state_t             r_state;
    state_t             w_next;
    logic               w_clr_fire;
    logic               r_run;
    logic               r_cnt_clr;
    logic               r_ms_tick;
    logic               r_sec_tick;
    logic [MS_W-1:0]    r_ms_cnt;
    logic [SEC_W-1:0]   r_sec_cnt;
    logic               w_ms_wrap;
    logic               w_sec_wrap;

    // Presses that are meaningless in the current state are dropped before
    // priority is applied, so e.g. start+stop in IDLE still starts.
    always_comb begin
        w_next     = r_state;
        w_clr_fire = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_clr) begin
                    w_clr_fire = 1'b1;
                end else if (w_start) begin
                    w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_stop) begin
                    w_next = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (w_clr) begin
                    w_next     = ST_IDLE;
                    w_clr_fire = 1'b1;
                end else if (w_start) begin
                    w_next = ST_RUN;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_run     <= 1'b0;
            r_cnt_clr <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_run     <= (w_next == ST_RUN);
            r_cnt_clr <= w_clr_fire;
        end
    end

    assign w_ms_wrap  = (r_state == ST_RUN) && (r_ms_cnt == MS_W'(MS_LIMIT - 1));
    assign w_sec_wrap = w_ms_wrap && (r_sec_cnt == SEC_W'(SEC_LIMIT - 1));

    // Position survives PAUSE and is only discarded when heading back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ms_cnt   <= '0;
            r_sec_cnt  <= '0;
            r_ms_tick  <= 1'b0;
            r_sec_tick <= 1'b0;
        end else begin
            r_ms_tick  <= w_ms_wrap;
            r_sec_tick <= w_sec_wrap;
            if (w_next == ST_IDLE) begin
                r_ms_cnt  <= '0;
                r_sec_cnt <= '0;
            end else if (r_state == ST_RUN) begin
                if (w_ms_wrap) begin
                    r_ms_cnt  <= '0;
                    r_sec_cnt <= w_sec_wrap ? '0 : r_sec_cnt + SEC_W'(1);
                end else begin
                    r_ms_cnt <= r_ms_cnt + MS_W'(1);
                end
            end
        end
    end

    assign run      = r_run;
    assign state    = r_state;
    assign cnt_clr  = r_cnt_clr;
    assign ms_tick  = r_ms_tick;
    assign sec_tick = r_sec_tick;

endmodule
